// File: rtl/demux32_reg.sv
// ============================================================================
// demux32_reg: steers a valid/ready word stream into one of two registered
// single-slot outputs and counts completed output handshakes per destination.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux32_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int c_NDEST = 2;

  logic [c_NDEST-1:0] w_out_ready;
  logic [c_NDEST-1:0] w_slot_free;
  logic [c_NDEST-1:0] w_pop;
  logic [c_NDEST-1:0] w_load;
  logic               w_accept;

  logic [c_NDEST-1:0] valid_q;
  logic [WIDTH-1:0]   data_q [c_NDEST];
  logic [CNT_W-1:0]   cnt_q  [c_NDEST];

  assign w_out_ready = {out1_ready, out0_ready};

  // A slot can take a word if it is empty or being drained this same cycle.
  assign w_slot_free = ~valid_q | w_out_ready;
  assign in_ready    = in_sel ? w_slot_free[1] : w_slot_free[0];
  assign w_accept    = in_valid & in_ready;

  generate
    for (genvar n = 0; n < c_NDEST; n++) begin : g_dest
      localparam logic c_SEL = 1'(n);

      logic             valid_d;
      logic [WIDTH-1:0] data_d;
      logic [CNT_W-1:0] cnt_d;

      assign w_pop[n]  = valid_q[n] & w_out_ready[n];
      assign w_load[n] = w_accept & (in_sel == c_SEL);

      always_comb begin
        valid_d = valid_q[n];
        data_d  = data_q[n];
        cnt_d   = cnt_q[n];
        if (w_pop[n]) begin
          cnt_d   = cnt_q[n] + CNT_W'(1);
          valid_d = 1'b0;
        end
        if (w_load[n]) begin
          valid_d = 1'b1;
          data_d  = in_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q[n] <= 1'b0;
          data_q[n]  <= '0;
          cnt_q[n]   <= '0;
        end else begin
          valid_q[n] <= valid_d;
          data_q[n]  <= data_d;
          cnt_q[n]   <= cnt_d;
        end
      end
    end
  endgenerate

  assign out0_valid = valid_q[0];
  assign out1_valid = valid_q[1];
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

endmodule

`default_nettype wire

// File: tb/tb_demux32_reg.sv
// ============================================================================
// tb_demux32_reg: directed and randomized checks of demux32_reg against a
// queue-based model of the two destination slots.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demux32_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out0_data, out1_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 1'b0;
  logic        out1_ready = 1'b0;
  logic [15:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  demux32_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Model: each slot is a queue holding at most one word; the visible data is
  // the most recently loaded word, and counters count completed pops mod 2^16.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;
  int unsigned pops0 = 0;
  int unsigned pops1 = 0;
  bit          live = 1'b0;

  function automatic bit model_room(input bit sel);
    if (sel) return (q1.size() == 0) || out1_ready;
    return (q0.size() == 0) || out0_ready;
  endfunction

  always @(posedge clk) begin
    bit p0, p1, room;
    if (rst) begin
      q0.delete(); q1.delete();
      last0 = '0; last1 = '0;
      pops0 = 0;  pops1 = 0;
      live  = 1'b1;
    end else if (live) begin
      p0   = (q0.size() != 0) && out0_ready;
      p1   = (q1.size() != 0) && out1_ready;
      room = model_room(in_sel);
      if (p0) begin void'(q0.pop_front()); pops0 = pops0 + 1; end
      if (p1) begin void'(q1.pop_front()); pops1 = pops1 + 1; end
      if (in_valid && room) begin
        if (in_sel) begin q1.push_back(in_data); last1 = in_data; end
        else        begin q0.push_back(in_data); last0 = in_data; end
      end
      if (q0.size() > 1 || q1.size() > 1) begin
        tests++; fails++;
        $display("FAIL model_overflow: slot occupancy q0=%0d q1=%0d, required <=1", q0.size(), q1.size());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the rising edge and after inputs settle.
  always @(negedge clk) begin
    #2;
    if (live) begin
      check("cyc_out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      check("cyc_out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      check("cyc_out0_data",  out0_data, last0);
      check("cyc_out1_data",  out1_data, last1);
      check("cyc_cnt0",       32'(cnt0), pops0 % 65536);
      check("cyc_cnt1",       32'(cnt1), pops1 % 65536);
      check("cyc_in_ready",   32'(in_ready), 32'(model_room(in_sel)));
    end
  end

  // Advance one cycle; returns at negedge+1 so inputs can be changed.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input bit s, input logic [31:0] d, input bit r0, input bit r1);
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, '0, 0, 0);
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    check("reset_out0_valid", 32'(out0_valid), 32'h0);
    check("reset_out1_valid", 32'(out1_valid), 32'h0);
    check("reset_out0_data",  out0_data, 32'h0);
    check("reset_cnt0",       32'(cnt0), 32'h0);
    check("reset_in_ready",   32'(in_ready), 32'h1);

    // Single word to out0, popped the cycle after it appears.
    set_in(1, 0, 32'h1234_5678, 1, 0);
    tick();
    set_in(0, 0, '0, 1, 0);
    check("t30_out0_valid", 32'(out0_valid), 32'h1);
    check("t30_out0_data",  out0_data, 32'h1234_5678);
    check("t30_out1_valid", 32'(out1_valid), 32'h0);
    tick();
    check("t30_cnt0", 32'(cnt0), 32'h1);
    check("t30_out0_empty", 32'(out0_valid), 32'h0);
    check("t30_out0_data_kept", out0_data, 32'h1234_5678);

    // Stall on out1, then pop and load on the same edge.
    set_in(1, 1, 32'hAAAA_0001, 0, 0);
    tick();
    set_in(1, 1, 32'hAAAA_0002, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t31_stall_ready", 32'(in_ready), 32'h0);
      check("t31_hold_data",   out1_data, 32'hAAAA_0001);
      tick();
    end
    out1_ready = 1'b1;
    #1;
    check("t31_ready_on_pop", 32'(in_ready), 32'h1);
    tick();
    set_in(0, 1, '0, 0, 0);
    check("t31_out1_valid", 32'(out1_valid), 32'h1);
    check("t31_out1_data",  out1_data, 32'hAAAA_0002);
    check("t31_cnt1",       32'(cnt1), 32'h1);

    // out1 full and stalled, out0 still accepts.
    set_in(1, 0, 32'h5, 0, 0);
    #1;
    check("t32_in_ready", 32'(in_ready), 32'h1);
    tick();
    set_in(0, 0, '0, 0, 0);
    check("t32_out0_data",  out0_data, 32'h5);
    check("t32_out0_valid", 32'(out0_valid), 32'h1);
    check("t32_out1_data",  out1_data, 32'hAAAA_0002);
    check("t32_out1_valid", 32'(out1_valid), 32'h1);

    // 100 back-to-back words alternating destination.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      set_in(1, i[0], 32'h100 + i, 1, 1);
      #1;
      check("t33_in_ready", 32'(in_ready), 32'h1);
      tick();
    end
    set_in(0, 0, '0, 1, 1);
    tick();
    check("t33_cnt0", 32'(cnt0), 32'd50);
    check("t33_cnt1", 32'(cnt1), 32'd50);
    check("t33_last0", out0_data, 32'h100 + 98);
    check("t33_last1", out1_data, 32'h100 + 99);

    // Counter wrap on out0.
    do_reset();
    set_in(1, 0, 32'h0, 1, 0);
    for (int i = 0; i < 65535; i++) begin
      in_data = i;
      tick();
    end
    set_in(0, 0, '0, 1, 0);
    tick();
    check("t34_cnt0_max", 32'(cnt0), 32'h0000_FFFF);
    set_in(1, 0, 32'hDEAD_BEEF, 1, 0);
    tick();
    set_in(0, 0, '0, 1, 0);
    tick();
    check("t34_cnt0_wrap", 32'(cnt0), 32'h0);

    // Reset overrides concurrent accept and pops.
    set_in(1, 0, 32'h0C0C_0000, 0, 0);
    tick();
    set_in(1, 1, 32'h0C0C_0001, 0, 0);
    tick();
    check("t35_pre_full0", 32'(out0_valid), 32'h1);
    check("t35_pre_full1", 32'(out1_valid), 32'h1);
    rst = 1'b1;
    set_in(1, 0, 32'hFFFF_FFFF, 1, 1);
    tick();
    check("t35_out0_valid", 32'(out0_valid), 32'h0);
    check("t35_out1_valid", 32'(out1_valid), 32'h0);
    check("t35_out0_data",  out0_data, 32'h0);
    check("t35_out1_data",  out1_data, 32'h0);
    check("t35_cnt0",       32'(cnt0), 32'h0);
    check("t35_cnt1",       32'(cnt1), 32'h0);
    check("t35_in_ready",   32'(in_ready), 32'h1);
    rst = 1'b0;

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0;
    set_in(0, 0, '0, 1, 1);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
